// File: rtl/countdown_pkg.sv
// Shared types and constants for the M:SS countdown timer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } t_cd_state;

  // Remaining time in seconds, 0..599 (9:59).
  typedef logic [9:0] t_seconds;

  // One-second prescaler; wide enough for a 31.5 MHz clock.
  typedef logic [24:0] t_prescale;

  // Renderer draws nothing for this code.
  localparam logic [3:0] DIGIT_BLANK = 4'hF;
  localparam int         SEC_PER_MIN = 60;

endpackage

// File: rtl/seconds_to_mmss.sv
// Binary seconds to M:SS digit converter.
// Latency: purely combinational.
// Backpressure: none.
// Ports:
//   seconds  - binary seconds, valid range 0..599
//   minutes  - minutes digit 0..9
//   tens     - tens-of-seconds digit 0..5
//   units    - units-of-seconds digit 0..9
// Values of 600 and above cannot be shown in one minutes digit, so all three
// digits fall back to blank instead of showing garbage.
module seconds_to_mmss
  import countdown_pkg::*;
(
  input  logic [9:0] seconds,
  output logic [3:0] minutes,
  output logic [3:0] tens,
  output logic [3:0] units
);

  logic [5:0] sec_in_min;

  always_comb begin
    minutes    = DIGIT_BLANK;
    tens       = DIGIT_BLANK;
    units      = DIGIT_BLANK;
    sec_in_min = '0;
    if (seconds < 10'(10 * SEC_PER_MIN)) begin
      sec_in_min = 6'(seconds % 10'(SEC_PER_MIN));
      minutes    = 4'(seconds / 10'(SEC_PER_MIN));
      tens       = 4'(sec_in_min / 6'd10);
      units      = 4'(sec_in_min % 6'd10);
    end
  end

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Game countdown timer: holds remaining seconds, decrements once per second
// while running, and drives registered M:SS digits to the digit renderer.
// Latency: digits/running/expired follow internal state by one clock; timeUp
// is a one-clock pulse the cycle after the state enters EXPIRED.
// Backpressure: none; load/start/pause/bonus are single-cycle pulses,
// priority load > start > pause.
// Ports:
//   clk, resetN            - clock, asynchronous active-low reset
//   load                   - reload INIT_SECONDS, return to IDLE
//   start                  - begin counting from IDLE or resume from PAUSED
//   pause                  - RUNNING -> PAUSED
//   bonus                  - add BONUS_SECONDS (clamped to MAX_SECONDS)
//   digit1/digit2/digit3   - minutes / tens-of-seconds / units-of-seconds
//   running, expired       - state decodes
//   timeUp                 - expiry pulse
// Build option COUNTDOWN_BLINK_EN: blink the digits during the last ten
// seconds and at 0:00 after expiry.
module countdown_timer_ctrl
  import countdown_pkg::*;
#(
  parameter int CLK_FREQ_HZ   = 31500000,
  parameter int INIT_SECONDS  = 90,
  parameter int BONUS_SECONDS = 5,
  parameter int MAX_SECONDS   = 599
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       load,
  input  logic       start,
  input  logic       pause,
  input  logic       bonus,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic       running,
  output logic       expired,
  output logic       timeUp
);

  localparam t_prescale   PRE_LAST  = t_prescale'(CLK_FREQ_HZ - 1);
  localparam t_seconds    INIT_VAL  = t_seconds'(INIT_SECONDS);
  localparam t_seconds    MAX_VAL   = t_seconds'(MAX_SECONDS);
  localparam logic [10:0] MAX_WIDE  = 11'(MAX_SECONDS);
  localparam logic [10:0] BONUS_VAL = 11'(BONUS_SECONDS);
  localparam logic [3:0]  INIT_MIN  = 4'(INIT_SECONDS / SEC_PER_MIN);
  localparam logic [3:0]  INIT_TEN  = 4'((INIT_SECONDS % SEC_PER_MIN) / 10);
  localparam logic [3:0]  INIT_UNIT = 4'(INIT_SECONDS % 10);

  t_cd_state   state, state_n;
  t_seconds    seconds_reg, seconds_n;
  t_prescale   prescaler, prescaler_n;
  logic        tick;
  logic [10:0] bonus_sum, bonus_tick_sum;
  t_seconds    bonus_add, bonus_tick;
  logic [3:0]  conv_min, conv_ten, conv_unit;
  logic        blank;

  // Bonus arithmetic is done one bit wider so the clamp sees the overflow.
  always_comb begin
    tick           = (state == RUNNING) && (prescaler == PRE_LAST);
    bonus_sum      = {1'b0, seconds_reg} + BONUS_VAL;
    bonus_tick_sum = bonus_sum - 11'd1;
    bonus_add      = (bonus_sum > MAX_WIDE) ? MAX_VAL : bonus_sum[9:0];
    bonus_tick     = (bonus_tick_sum > MAX_WIDE) ? MAX_VAL : bonus_tick_sum[9:0];
  end

  always_comb begin
    state_n     = state;
    seconds_n   = seconds_reg;
    prescaler_n = prescaler;
    if (load) begin
      state_n     = IDLE;
      seconds_n   = INIT_VAL;
      prescaler_n = '0;
    end else begin
      case (state)
        IDLE: begin
          if (bonus) seconds_n = bonus_add;
          if (start) begin
            prescaler_n = '0;
            state_n     = (seconds_reg == '0) ? EXPIRED : RUNNING;
          end
        end
        RUNNING: begin
          prescaler_n = tick ? '0 : prescaler + t_prescale'(1);
          if (tick && bonus)  seconds_n = bonus_tick;
          else if (tick)      seconds_n = seconds_reg - t_seconds'(1);
          else if (bonus)     seconds_n = bonus_add;
          // A bonus landing on the tick keeps the count above zero.
          if (tick && !bonus && (seconds_reg == t_seconds'(1))) state_n = EXPIRED;
          else if (pause && !start)                                state_n = PAUSED;
        end
        PAUSED: begin
          if (bonus) seconds_n = bonus_add;
          if (start) state_n = RUNNING;
        end
        EXPIRED: begin
`ifdef COUNTDOWN_BLINK_EN
          // Free-running so the expired 0:00 keeps blinking.
          prescaler_n = (prescaler == PRE_LAST) ? '0 : prescaler + t_prescale'(1);
`else
          prescaler_n = prescaler;
`endif
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= IDLE;
      seconds_reg <= INIT_VAL;
      prescaler   <= '0;
    end else begin
      state       <= state_n;
      seconds_reg <= seconds_n;
      prescaler   <= prescaler_n;
    end
  end

  seconds_to_mmss u_conv (
    .seconds (seconds_reg),
    .minutes (conv_min),
    .tens    (conv_ten),
    .units   (conv_unit)
  );

`ifdef COUNTDOWN_BLINK_EN
  localparam t_prescale PRE_HALF = t_prescale'(CLK_FREQ_HZ / 2);
  // Second half of each second is dark in the last ten seconds and at expiry.
  assign blank = (prescaler >= PRE_HALF) &&
                 (((state == RUNNING) && (seconds_reg <= t_seconds'(10))) ||
                  (state == EXPIRED));
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      digit1  <= INIT_MIN;
      digit2  <= INIT_TEN;
      digit3  <= INIT_UNIT;
      running <= 1'b0;
      expired <= 1'b0;
      timeUp  <= 1'b0;
    end else begin
      digit1  <= blank ? DIGIT_BLANK : conv_min;
      digit2  <= blank ? DIGIT_BLANK : conv_ten;
      digit3  <= blank ? DIGIT_BLANK : conv_unit;
      running <= (state == RUNNING);
      expired <= (state == EXPIRED);
      // expired still holds last cycle's decode, so this fires once on entry;
      // a simultaneous load cancels the pulse.
      timeUp  <= (state == EXPIRED) && !expired && !load;
    end
  end

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Self-checking bench for countdown_timer_ctrl with a one-second tick of four
// clocks: directed scenarios followed by random pulses, all scored against a
// behavioural model of the timer.
module tb_countdown_timer_ctrl;

  localparam int CLK   = 4;
  localparam int INIT  = 90;
  localparam int BONUS = 5;
  localparam int MAXS  = 599;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_EXP   = 3;

  logic       clk = 1'b0;
  logic       resetN, load, start, pause, bonus;
  logic [3:0] digit1, digit2, digit3;
  logic       running, expired, timeUp;

  countdown_timer_ctrl #(
    .CLK_FREQ_HZ   (CLK),
    .INIT_SECONDS  (INIT),
    .BONUS_SECONDS (BONUS),
    .MAX_SECONDS   (MAXS)
  ) dut (
    .clk     (clk),
    .resetN  (resetN),
    .load    (load),
    .start   (start),
    .pause   (pause),
    .bonus   (bonus),
    .digit1  (digit1),
    .digit2  (digit2),
    .digit3  (digit3),
    .running (running),
    .expired (expired),
    .timeUp  (timeUp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] d1;
    logic [3:0] d2;
    logic [3:0] d3;
    logic       run;
    logic       exp;
    logic       tu;
  } obs_t;

  obs_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_sample = 0;

  // Model: what the timer is doing, remaining seconds, elapsed part of the
  // current second, and whether it was already expired one step ago.
  int m_mode, m_secs, m_phase;
  bit m_prev_exp;

  function automatic int min_i(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic void model_reset();
    m_mode     = M_IDLE;
    m_secs     = INIT;
    m_phase    = 0;
    m_prev_exp = 1'b0;
  endfunction

  // Outputs the DUT should show after the coming clock edge.
  function automatic obs_t expect_now(bit ld);
    obs_t e;
    bit   blank;
    blank = 1'b0;
`ifdef COUNTDOWN_BLINK_EN
    blank = (m_phase >= CLK / 2) &&
            (((m_mode == M_RUN) && (m_secs <= 10)) || (m_mode == M_EXP));
`endif
    e.d1  = blank ? 4'hF : 4'(m_secs / 60);
    e.d2  = blank ? 4'hF : 4'((m_secs % 60) / 10);
    e.d3  = blank ? 4'hF : 4'(m_secs % 10);
    e.run = (m_mode == M_RUN);
    e.exp = (m_mode == M_EXP);
    e.tu  = (m_mode == M_EXP) && !m_prev_exp && !ld;
    return e;
  endfunction

  function automatic void model_step(bit ld, bit st, bit ps, bit bn);
    bit tick, was_zero;
    m_prev_exp = (m_mode == M_EXP);
    if (ld) begin
      m_mode  = M_IDLE;
      m_secs  = INIT;
      m_phase = 0;
      return;
    end
    tick = (m_mode == M_RUN) && (m_phase == CLK - 1);
    case (m_mode)
      M_IDLE: begin
        was_zero = (m_secs == 0);
        if (bn) m_secs = min_i(m_secs + BONUS, MAXS);
        if (st) begin
          m_phase = 0;
          m_mode  = was_zero ? M_EXP : M_RUN;
        end
      end
      M_RUN: begin
        m_phase = (m_phase + 1) % CLK;
        if (tick && bn) m_secs = min_i(m_secs + BONUS - 1, MAXS);
        else if (tick) begin
          m_secs = m_secs - 1;
          if (m_secs == 0) m_mode = M_EXP;
        end else if (bn) m_secs = min_i(m_secs + BONUS, MAXS);
        if (m_mode == M_RUN && ps && !st) m_mode = M_PAUSE;
      end
      M_PAUSE: begin
        if (bn) m_secs = min_i(m_secs + BONUS, MAXS);
        if (st) m_mode = M_RUN;
      end
      default: begin
`ifdef COUNTDOWN_BLINK_EN
        m_phase = (m_phase + 1) % CLK;
`endif
      end
    endcase
  endfunction

  function automatic obs_t cur_obs();
    obs_t o;
    o.d1  = digit1;
    o.d2  = digit2;
    o.d3  = digit3;
    o.run = running;
    o.exp = expired;
    o.tu  = timeUp;
    return o;
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s @%0t: got digits=%h,%h,%h running=%b expired=%b timeUp=%b; want digits=%h,%h,%h running=%b expired=%b timeUp=%b",
               name, $time, got.d1, got.d2, got.d3, got.run, got.exp, got.tu,
               want.d1, want.d2, want.d3, want.run, want.exp, want.tu);
    end
  endtask

  // Monitor: every clock edge with a queued expectation is compared.
  initial begin
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_sample++;
        check($sformatf("sample%0d", n_sample), cur_obs(), e);
      end
    end
  end

  task automatic drive(input bit ld, input bit st, input bit ps, input bit bn);
    load  = ld;
    start = st;
    pause = ps;
    bonus = bn;
    sb.push_back(expect_now(ld));
    model_step(ld, st, ps, bn);
  endtask

  task automatic cycle(input bit ld, input bit st, input bit ps, input bit bn);
    @(negedge clk);
    drive(ld, st, ps, bn);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Reset asserted between edges must take effect without waiting for a clock.
  task automatic async_reset(input string name);
    @(negedge clk);
    {load, start, pause, bonus} = 4'b0;
    #1 resetN = 1'b0;
    #1;
    model_reset();
    check(name, cur_obs(), expect_now(1'b0));
    @(negedge clk);
    resetN = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    resetN = 1'b0;
    {load, start, pause, bonus} = 4'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_values", cur_obs(), expect_now(1'b0));
    resetN = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    // Start from IDLE, first decrement four clocks later.
    idle(3);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    idle(10);

    // Pause mid-second, hold, then resume the partial second.
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    idle(20);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    idle(6);

    // Run to expiry (passes 1:01 -> 1:00 -> 0:59 on the way).
    for (int i = 0; i < 500 && m_mode != M_EXP; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    idle(3);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Saturate at 9:59, drop to 9:57, bonus clamps back to 9:59.
    for (int i = 0; i < 110; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    idle(8);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    idle(4);

    // Bonus on the tick cycle at 0:30.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 400 && !(m_secs == 30 && m_phase == CLK - 1); i++)
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    idle(6);

    // Asynchronous reset while counting at 0:45.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 400 && m_secs != 45; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    async_reset("mid_count_reset");
    idle(3);

    // Last ten seconds and expiry (blink pattern when built with blinking).
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 500 && m_mode != M_EXP; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    idle(10);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);

    // Random pulse mix.
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 29) == 0, $urandom_range(0, 24) == 0);

    @(negedge clk);
    {load, start, pause, bonus} = 4'b0;
    #2;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
